// File: rtl/ultrasonic_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_pkg
// Shared types and helpers for the ultrasonic ranger front end.
//   state_t     : shot sequencer states
//   timer_width : bits needed by the single shared timer, which must hold
//                 the largest of the trigger, timeout and holdoff intervals
// ---------------------------------------------------------------------------
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_t;

   function automatic int timer_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// ---------------------------------------------------------------------------
// echo_sync
// Synchroniser and edge detector for one asynchronous echo input.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_echo       : raw asynchronous echo
//   o_level      : echo after SYNC_STAGES flops
//   o_rise       : one-cycle pulse on a 0->1 transition of o_level
//   o_fall       : one-cycle pulse on a 1->0 transition of o_level
// ---------------------------------------------------------------------------
module echo_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_echo,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level_d;
   logic                   w_level;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync    <= '0;
         r_level_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_echo};
         r_level_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_level = r_sync[SYNC_STAGES-1];
   assign o_level = w_level;
   assign o_rise  = w_level & ~r_level_d;
   assign o_fall  = ~w_level & r_level_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// ultrasonic_ranger
// Round-robin multi-channel ultrasonic front end: fires one trigger at a
// time, measures the echo high time in clock cycles and reports it tagged
// with the channel index. A holdoff follows every shot.
//   clk, reset  : clock, asynchronous active-high reset
//   enable      : level; keeps the channels firing while high (sampled in IDLE)
//   echo        : raw asynchronous echo inputs, one per channel
//   trig        : trigger outputs, at most one bit high
//   ch_idx      : channel of the last report
//   width       : last measured echo width (saturating)
//   width_valid : one-cycle strobe, new width on ch_idx
//   timeout     : one-cycle strobe, ch_idx produced no complete echo
//   busy        : sequencer is not IDLE
// ---------------------------------------------------------------------------
module ultrasonic_ranger
   import ultrasonic_pkg::*;
#(
   parameter  int NUM_CH         = 4,
   parameter  int COUNT_W        = 24,
   parameter  int TRIG_CYCLES    = 1000,
   parameter  int TIMEOUT_CYCLES = 3800000,
   parameter  int HOLDOFF_CYCLES = 6000000,
   parameter  int SYNC_STAGES    = 2,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_CH-1:0]  echo,
   output logic [NUM_CH-1:0]  trig,
   output logic [CH_W-1:0]    ch_idx,
   output logic [COUNT_W-1:0] width,
   output logic               width_valid,
   output logic               timeout,
   output logic               busy
);

   localparam int TMR_W = timer_width(TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES);

   localparam logic [TMR_W-1:0]   TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
   localparam logic [TMR_W-1:0]   TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]   HO_LAST   = TMR_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

   state_t               r_state, w_next;
   logic [TMR_W-1:0]     r_timer;
   logic [COUNT_W-1:0]   r_count;
   logic [CH_W-1:0]      r_cur_ch;

   logic [NUM_CH-1:0]    w_echo_s, w_rise, w_fall;
   logic                 w_cur_lvl, w_cur_rise, w_cur_fall;
   logic                 w_to_hit;
   logic                 w_report, w_expire;
   logic                 w_tmr_clr;

   // ---- per-channel synchronisers -----------------------------------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      echo_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .i_clk   (clk),
         .i_rst   (reset),
         .i_echo  (echo[g]),
         .o_level (w_echo_s[g]),
         .o_rise  (w_rise[g]),
         .o_fall  (w_fall[g])
      );
   end

   // Only the channel being fired is looked at; the others are ignored.
   assign w_cur_lvl  = w_echo_s[r_cur_ch];
   assign w_cur_rise = w_rise[r_cur_ch];
   assign w_cur_fall = w_fall[r_cur_ch];

   // The timer runs from WAIT_RISE entry through MEASURE, so the timeout
   // bounds the whole listen window. ">=" keeps a rise on the very last
   // WAIT_RISE cycle from slipping past the limit.
   assign w_to_hit = (r_timer >= TO_LAST);

   // ---- FSM: state register ----------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // ---- FSM: next state ---------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (enable) w_next = TRIG;
         TRIG:      if (r_timer == TRIG_LAST) w_next = WAIT_RISE;
         WAIT_RISE: begin
            if (w_to_hit)        w_next = HOLDOFF;
            else if (w_cur_rise) w_next = MEASURE;
         end
         // A fall on the timeout cycle still counts as a completed echo.
         MEASURE:   if (w_cur_fall || w_to_hit) w_next = HOLDOFF;
         HOLDOFF:   if (r_timer == HO_LAST) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // ---- FSM: outputs ------------------------------------------------------
   // trig/busy decode straight from the state register so reset drops them
   // without waiting for a clock edge.
   always_comb begin
      trig = '0;
      if (r_state == TRIG) trig[r_cur_ch] = 1'b1;
      busy     = (r_state != IDLE);
      w_report = (r_state == MEASURE) && w_cur_fall;
      w_expire = ((r_state == WAIT_RISE) || (r_state == MEASURE)) && w_to_hit && !w_report;
   end

   // Timer restarts on every state change except WAIT_RISE->MEASURE.
   assign w_tmr_clr = (r_state == IDLE) || ((w_next != r_state) && (w_next != MEASURE));

   // ---- datapath ----------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer     <= '0;
         r_count     <= '0;
         r_cur_ch    <= '0;
         width       <= '0;
         ch_idx      <= '0;
         width_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         r_timer <= w_tmr_clr ? '0 : r_timer + 1'b1;

         // The rise cycle is itself the first high cycle, hence count=1.
         if (r_state == WAIT_RISE && w_next == MEASURE)
            r_count <= COUNT_W'(1);
         else if (r_state == MEASURE && w_cur_lvl && r_count != CNT_MAX)
            r_count <= r_count + 1'b1;

         if (r_state == HOLDOFF && r_timer == HO_LAST)
            r_cur_ch <= (r_cur_ch == CH_LAST) ? '0 : r_cur_ch + 1'b1;

         width_valid <= w_report;
         timeout     <= w_expire;
         if (w_report) begin
            width  <= r_count;
            ch_idx <= r_cur_ch;
         end else if (w_expire) begin
            ch_idx <= r_cur_ch;
         end
      end
   end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
module tb_ultrasonic_ranger;

   localparam int NUM_CH         = 2;
   localparam int COUNT_W        = 8;
   localparam int TRIG_CYCLES    = 10;
   localparam int TIMEOUT_CYCLES = 400;
   localparam int HOLDOFF_CYCLES = 50;
   localparam int SYNC_STAGES    = 2;
   localparam int WMAX           = (1 << COUNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset, enable;
   logic [NUM_CH-1:0]  echo, trig;
   logic [0:0]         ch_idx;
   logic [COUNT_W-1:0] width;
   logic               width_valid, timeout, busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference-model state
   int m_ch, m_width, last_strobe;
   bit have_prev;

   typedef struct {
      int d;      // echo rise, cycles after the trigger falls
      int len;    // raw echo high time
      bit pre;    // echo held high from before the trigger
      bit none;   // no echo at all
      bit tog;    // random activity on the other channel
      int exp_pt; // cycles from trigger fall to strobe
      bit exp_to;
      int exp_w;
   } vec_t;

   vec_t tbl[10];

   ultrasonic_ranger #(
      .NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .TRIG_CYCLES(TRIG_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
      .ch_idx(ch_idx), .width(width), .width_valid(width_valid),
      .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result of one shot from the observable rules: a completed echo is
   // reported SYNC_STAGES+1 cycles after its raw fall unless that is later
   // than the timeout limit; widths clip at the counter maximum.
   function automatic void model(input int d, input int len, input bit pre, input bit none,
                                 output int pt, output bit to, output int w);
      int rpt;
      pt = TIMEOUT_CYCLES;
      to = 1'b1;
      w  = m_width;
      if (!pre && !none) begin
         rpt = d + len + SYNC_STAGES + 1;
         if (rpt <= TIMEOUT_CYCLES) begin
            pt = rpt;
            to = 1'b0;
            w  = (len > WMAX) ? WMAX : len;
         end
      end
   endfunction

   task automatic wait_trig(output int n);
      n = 0;
      while (trig == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic do_shot(input string tag, input int d, input int len, input bit pre,
                          input bit none, input bit tog, input int drop_at,
                          input int exp_pt, input bit exp_to, input int exp_w);
      int n, pt;
      if (pre) echo[m_ch] = 1'b1;
      wait_trig(n);
      chk({tag, "_trig_onehot"}, int'(trig), 1 << m_ch);
      chk({tag, "_busy"}, int'(busy), 1);
      if (have_prev) chk({tag, "_holdoff_gap"}, cyc - last_strobe, HOLDOFF_CYCLES + 1);
      n = 0;
      while (trig != '0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_trig_len"}, n, TRIG_CYCLES);
      pt = -1;
      for (int k = 0; k <= TIMEOUT_CYCLES + 10; k++) begin
         if (width_valid || timeout) begin
            pt = k;
            break;
         end
         if (k == drop_at) enable = 1'b0;
         echo[m_ch] = pre || (!none && k >= d && k < d + len);
         if (tog) echo[1 - m_ch] = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      last_strobe = cyc;
      have_prev   = 1'b1;
      echo        = '0;
      chk({tag, "_evt_cycle"}, pt, exp_pt);
      chk({tag, "_timeout"}, int'(timeout), int'(exp_to));
      chk({tag, "_valid"}, int'(width_valid), int'(!exp_to));
      chk({tag, "_width"}, int'(width), exp_w);
      chk({tag, "_ch_idx"}, int'(ch_idx), m_ch);
      @(negedge clk);
      chk({tag, "_one_cycle"}, int'(width_valid | timeout), 0);
      chk({tag, "_width_hold"}, int'(width), exp_w);
      m_width = exp_w;
      m_ch    = (m_ch + 1) % NUM_CH;
   endtask

   initial begin
      int n, ept, ew, seen;
      bit eto;
      reset = 1'b1; enable = 1'b0; echo = '0;
      m_ch = 0; m_width = 0; have_prev = 1'b0; last_strobe = 0;

      //           d    len  pre none tog  pt   to  w
      tbl[0] = '{ 30,  120, 0,  0,   0,  153, 0, 120};
      tbl[1] = '{ 10,   75, 0,  0,   0,   88, 0,  75};
      tbl[2] = '{  0,    0, 0,  1,   0,  400, 1,  75};  // no echo: width kept
      tbl[3] = '{  5,    1, 0,  0,   0,    9, 0,   1};  // shortest echo
      tbl[4] = '{ 20,  300, 0,  0,   0,  323, 0, 255};  // saturates
      tbl[5] = '{  0,  397, 0,  0,   0,  400, 0, 255};  // fall on timeout cycle wins
      tbl[6] = '{  0,  398, 0,  0,   0,  400, 1, 255};  // one cycle too long
      tbl[7] = '{  3,   50, 0,  0,   1,   56, 0,  50};
      tbl[8] = '{  0,    0, 1,  0,   1,  400, 1,  50};  // already high: no rise
      tbl[9] = '{396,    1, 0,  0,   0,  400, 0,   1};  // late rise, fall wins

      repeat (3) @(negedge clk);
      chk("rst_trig", int'(trig), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(width_valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_width", int'(width), 0);
      chk("rst_ch_idx", int'(ch_idx), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_trig", int'(trig), 0);

      enable = 1'b1;
      foreach (tbl[i])
         do_shot($sformatf("vec%0d", i), tbl[i].d, tbl[i].len, tbl[i].pre, tbl[i].none,
                 tbl[i].tog, -1, tbl[i].exp_pt, tbl[i].exp_to, tbl[i].exp_w);

      for (int i = 0; i < 12; i++) begin
         int d, len, sel;
         bit pre, none, tog;
         d    = $urandom_range(0, 150);
         len  = $urandom_range(1, 300);
         sel  = $urandom_range(0, 7);
         pre  = (sel == 0);
         none = (sel == 1);
         tog  = 1'($urandom_range(0, 1));
         model(d, len, pre, none, ept, eto, ew);
         do_shot($sformatf("rnd%0d", i), d, len, pre, none, tog, -1, ept, eto, ew);
      end

      // enable dropped mid-measurement: shot completes, then stops after holdoff
      model(20, 60, 1'b0, 1'b0, ept, eto, ew);
      do_shot("drop", 20, 60, 1'b0, 1'b0, 1'b0, 30, ept, eto, ew);
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drop_busy_fall", cyc - last_strobe, HOLDOFF_CYCLES);
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (trig != '0) seen = 1;
      end
      chk("drop_no_refire", seen, 0);
      chk("drop_idle_busy", int'(busy), 0);
      have_prev = 1'b0;
      enable    = 1'b1;

      // reset in the middle of a channel-1 measurement
      if (m_ch != 1) begin
         model(5, 40, 1'b0, 1'b0, ept, eto, ew);
         do_shot("pre_rst", 5, 40, 1'b0, 1'b0, 1'b0, -1, ept, eto, ew);
      end
      wait_trig(n);
      chk("rst_shot_trig", int'(trig), 2);
      n = 0;
      while (trig != '0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      for (int k = 0; k < 30; k++) begin
         echo[1] = (k >= 5);
         @(negedge clk);
      end
      #3 reset = 1'b1;
      #1;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_trig", int'(trig), 0);
      chk("rst_mid_width", int'(width), 0);
      echo = '0;
      repeat (4) begin
         @(negedge clk);
         chk("rst_mid_no_strobe", int'(width_valid | timeout), 0);
      end
      reset     = 1'b0;
      m_ch      = 0;
      have_prev = 1'b0;
      wait_trig(n);
      chk("rst_resume_ch0", int'(trig), 1);
      repeat (3) @(negedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_trig_async", int'(trig), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
